// File: rtl/roulette_wheel.sv
// Roulette wheel: an LFSR picks a hidden target on a spin edge, then the wheel
// position steps with a growing period and stops once it lands on the target.
module roulette_wheel #(
  parameter int TICK_DIV  = 4,
  parameter int NUM_STEPS = 16
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       spin,
  input  logic       ack,
  output logic [4:0] randnum,
  output logic       result_valid,
  output logic       spinning,
  output logic [4:0] wheel_pos
);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_DONE} state_t;

  localparam logic [15:0] TICK_W16 = 16'(TICK_DIV);
  localparam logic [15:0] NUM_W16  = 16'(NUM_STEPS);
  localparam logic [7:0]  NUM_W8   = 8'(NUM_STEPS);

  state_t      state_q;
  logic [4:0]  lfsr_q, lfsr_d;
  logic        spin_d_q;
  logic        spin_edge;
  logic [4:0]  target_q;
  logic [4:0]  pos_q, pos_d;
  logic [4:0]  randnum_q;
  logic        rv_q, spinning_q;
  logic [15:0] tick_q, period;
  logic [7:0]  step_q, step_d;
  logic        period_end;

  always_comb begin
    lfsr_d     = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    spin_edge  = spin & ~spin_d_q;
    pos_d      = (pos_q == 5'd31) ? 5'd1 : pos_q + 5'd1;
    step_d     = (step_q < NUM_W8) ? step_q + 8'd1 : step_q;
    // Period grows by TICK_DIV per step, then holds at its final length.
    period     = (step_q < NUM_W8) ? TICK_W16 * ({8'd0, step_q} + 16'd1)
                                   : TICK_W16 * NUM_W16;
    period_end = (tick_q == period - 16'd1);
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 5'b00001;
      spin_d_q   <= 1'b0;
      target_q   <= 5'd0;
      pos_q      <= 5'd1;
      randnum_q  <= 5'd0;
      rv_q       <= 1'b0;
      spinning_q <= 1'b0;
      tick_q     <= 16'd0;
      step_q     <= 8'd0;
    end else begin
      lfsr_q   <= lfsr_d;
      spin_d_q <= spin;
      case (state_q)
        S_IDLE: begin
          if (spin_edge) begin
            target_q   <= lfsr_q;
            tick_q     <= 16'd0;
            step_q     <= 8'd0;
            spinning_q <= 1'b1;
            state_q    <= S_SPIN;
          end
        end
        S_SPIN: begin
          if (period_end) begin
            pos_q  <= pos_d;
            tick_q <= 16'd0;
            step_q <= step_d;
            // Only stop on the target once the deceleration phase is complete.
            if ((step_d == NUM_W8) && (pos_d == target_q)) begin
              randnum_q  <= target_q;
              rv_q       <= 1'b1;
              spinning_q <= 1'b0;
              state_q    <= S_DONE;
            end
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        S_DONE: begin
          if (ack) begin
            rv_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign randnum      = randnum_q;
  assign result_valid = rv_q;
  assign spinning     = spinning_q;
  assign wheel_pos    = pos_q;

endmodule

// File: tb/tb_roulette_wheel.sv
// Directed bench: a default-parameter wheel plus a TICK_DIV=1/NUM_STEPS=1 wheel
// sharing clock and reset, checked with immediate assertions.
module tb_roulette_wheel;

  logic       Clock = 1'b0;
  logic       reset;
  logic       spin_a, ack_a, spin_b, ack_b;
  logic [4:0] rn_a, wp_a, rn_b, wp_b;
  logic       rv_a, sp_a, rv_b, sp_b;
  int         total = 0;
  int         bad   = 0;
  logic [4:0] m;
  logic [4:0] tgt;
  logic [4:0] prev;
  logic [31:0] seen;
  int         cnt, k, done;

  always #5 Clock = ~Clock;

  roulette_wheel u_dut (
    .Clock(Clock), .reset(reset), .spin(spin_a), .ack(ack_a),
    .randnum(rn_a), .result_valid(rv_a), .spinning(sp_a), .wheel_pos(wp_a)
  );

  roulette_wheel #(.TICK_DIV(1), .NUM_STEPS(1)) u_fast (
    .Clock(Clock), .reset(reset), .spin(spin_b), .ack(ack_b),
    .randnum(rn_b), .result_valid(rv_b), .spinning(sp_b), .wheel_pos(wp_b)
  );

  function automatic logic [4:0] nxt(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    if (!reset) m = nxt(m);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    spin_a = 1'b0; ack_a = 1'b0;
    spin_b = 1'b1; ack_b = 1'b0;
    m      = 5'd1;
    seen   = 32'd0;
    #2;
    tick; tick;

    chk("rst_wp_a", 32'(wp_a), 32'd1);
    chk("rst_rn_a", 32'(rn_a), 32'd0);
    chk("rst_rv_a", 32'(rv_a), 32'd0);
    chk("rst_sp_a", 32'(sp_a), 32'd0);
    chk("rst_wp_b", 32'(wp_b), 32'd1);
    chk("rst_sp_b", 32'(sp_b), 32'd0);
    chk("rst_lfsr", 32'(u_dut.lfsr_q), 32'd1);

    // Release: u_fast sees spin held high as an edge on the first clock.
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick;
      chk("lfsr_seq", 32'(u_dut.lfsr_q), 32'(m));
      chk("lfsr_unique", 32'(seen[u_dut.lfsr_q]), 32'd0);
      seen[u_dut.lfsr_q] = 1'b1;
      if (i == 1) begin
        chk("fast_spin", 32'(sp_b), 32'd1);
        chk("fast_pos1", 32'(wp_b), 32'd1);
      end else begin
        chk("fast_pos", 32'(wp_b), 32'(i));
      end
      chk("fast_rv_low", 32'(rv_b), 32'd0);
    end
    chk("lfsr_wrap", 32'(u_dut.lfsr_q), 32'd1);
    chk("lfsr_zero_unseen", 32'(seen[0]), 32'd0);

    tick;
    chk("fast_wp_done", 32'(wp_b), 32'd1);
    chk("fast_rv_done", 32'(rv_b), 32'd1);
    chk("fast_rn_done", 32'(rn_b), 32'd1);
    chk("fast_sp_done", 32'(sp_b), 32'd0);

    for (int i = 0; i < 100; i++) begin
      tick;
      chk("hold_rv", 32'(rv_b), 32'd1);
      chk("hold_rn", 32'(rn_b), 32'd1);
    end

    // ack and a spin edge in the same DONE cycle: ack wins, spin is dropped.
    spin_b = 1'b0;
    tick;
    spin_b = 1'b1; ack_b = 1'b1;
    tick;
    ack_b = 1'b0;
    chk("ack_rv", 32'(rv_b), 32'd0);
    chk("ack_sp", 32'(sp_b), 32'd0);
    chk("ack_rn_kept", 32'(rn_b), 32'd1);
    tick; tick;
    chk("no_respin", 32'(sp_b), 32'd0);
    chk("no_respin_rv", 32'(rv_b), 32'd0);

    // Default wheel: target is the LFSR value sampled at the edge clock.
    tgt = m;
    spin_a = 1'b1;
    tick;
    chk("spin_start", 32'(sp_a), 32'd1);
    prev = wp_a; cnt = 0; k = 0; done = 0;
    for (int c = 0; c < 3000 && done == 0; c++) begin
      if (c % 7 == 3) spin_a = ~spin_a;
      tick;
      cnt++;
      if (wp_a !== prev) begin
        chk("gap", 32'(cnt), 32'(4 * ((k < 16) ? k + 1 : 16)));
        k++;
        cnt = 0;
        prev = wp_a;
      end
      if (rv_a) done = 1;
      else chk("spinning", 32'(sp_a), 32'd1);
    end
    chk("spin_done", 32'(done), 32'd1);
    chk("randnum", 32'(rn_a), 32'(tgt));
    chk("wp_target", 32'(wp_a), 32'(tgt));
    chk("steps_min", 32'(k >= 16), 32'd1);
    chk("steps_max", 32'(k <= 46), 32'd1);
    chk("sp_after", 32'(sp_a), 32'd0);

    spin_a = 1'b0; ack_a = 1'b1;
    tick;
    ack_a = 1'b0;
    chk("ack_a_rv", 32'(rv_a), 32'd0);
    chk("ack_a_rn", 32'(rn_a), 32'(tgt));

    // Asynchronous reset in the middle of a spin.
    spin_a = 1'b1;
    tick;
    for (int i = 0; i < 40; i++) tick;
    chk("mid_spin", 32'(sp_a), 32'd1);
    #3;
    reset = 1'b1;
    m = 5'd1;
    #1;
    chk("arst_wp", 32'(wp_a), 32'd1);
    chk("arst_rn", 32'(rn_a), 32'd0);
    chk("arst_rv", 32'(rv_a), 32'd0);
    chk("arst_sp", 32'(sp_a), 32'd0);
    chk("arst_lfsr", 32'(u_dut.lfsr_q), 32'd1);
    tick; tick;
    spin_a = 1'b0; spin_b = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    chk("post_rst_rv", 32'(rv_a), 32'd0);
    chk("post_rst_sp", 32'(sp_a), 32'd0);
    chk("post_rst_wp", 32'(wp_a), 32'd1);
    chk("post_rst_lfsr", 32'(u_dut.lfsr_q), 32'(m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
